// File: rtl/fetch_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_buffer
//
// Instruction-fetch front end that sits in front of the decode stage. It issues
// sequential word fetches to instruction memory and stores the returned words,
// together with their PCs, in a small FIFO. The core takes them from the FIFO
// through a valid/ready port.
//
// A redirect from Execute does three things: it clears the FIFO, it restarts
// fetch at the target, and it marks every in-flight request as stale. The
// responses to those stale requests are dropped when they return.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   imem_req_valid/addr      fetch request (word-aligned address)
//   imem_req_ready           memory accepts the request
//   imem_rsp_valid/data      in-order instruction response
//   redirect_valid/pc        taken branch/jump target (bits [1:0] ignored)
//   instr_valid/out/pc       FIFO head: NOP / PC 0 when empty
//   instr_ready              core consumes the head
// ---------------------------------------------------------------------------
module fetch_prefetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'h1000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CR_W  = CNT_W + 2;
   localparam logic [31:0] NOP = 32'h0000_0013;

   // FLUSH is active exactly while stale responses are still expected.
   typedef enum logic {FETCH, FLUSH} state_t;

   state_t             state;
   logic [31:0]        fetch_pc;
   logic [31:0]        rsp_pc;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   outstanding;
   logic [CNT_W-1:0]   discard;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [31:0]        pc_mem    [DEPTH];
   logic [31:0]        instr_mem [DEPTH];

   logic [CR_W-1:0]    credit_used;
   logic               req_fire;
   logic               rsp_drop;
   logic               rsp_fill;
   logic               push;
   logic               pop;
   logic [CNT_W-1:0]   discard_redir;
   logic [31:0]        redir_target;
   logic               unused_pc_lsbs;

   function automatic logic [31:0] next_word(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Every buffered, in-flight or stale fetch holds one FIFO slot in reserve.
   // Because of this, a response can never find the FIFO full.
   assign credit_used    = CR_W'(count) + CR_W'(outstanding) + CR_W'(discard);
   // rst is included so the request drops at the moment reset is asserted.
   // A redirect withdraws a pending request that has not been accepted.
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < CR_W'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response that arrives with nothing outstanding is a protocol error.
   // It is ignored.
   assign rsp_drop = imem_rsp_valid && (state == FLUSH);
   assign rsp_fill = imem_rsp_valid && (state == FETCH) && (outstanding != '0);
   assign push     = rsp_fill && !redirect_valid;
   assign pop      = instr_valid && instr_ready && !redirect_valid;

   assign redir_target   = {redirect_pc[31:2], 2'b00};
   assign unused_pc_lsbs = ^redirect_pc[1:0];

   // Every in-flight request becomes stale. A response that is consumed in
   // the redirect cycle (dropped or not) needs no further discard slot.
   assign discard_redir = discard + outstanding + CNT_W'(req_fire)
                          - CNT_W'(rsp_drop || rsp_fill);

   // No bypass: an entry is visible only the cycle after it is written.
   assign instr_valid = (count != '0);
   assign instr_out   = instr_valid ? instr_mem[rd_ptr] : NOP;
   assign instr_pc    = instr_valid ? pc_mem[rd_ptr]    : 32'd0;

   // ---- control state: fetch/response PCs, counters, pointers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redir_target;
         rsp_pc      <= redir_target;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
         discard     <= discard_redir;
         state       <= (discard_redir != '0) ? FLUSH : FETCH;
      end else begin
         if (req_fire) fetch_pc <= next_word(fetch_pc);
         if (push) begin
            rsp_pc <= next_word(rsp_pc);
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count       <= count + CNT_W'(push) - CNT_W'(pop);
         outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fill);
         if (rsp_drop) begin
            discard <= discard - CNT_W'(1);
            if (discard == CNT_W'(1)) state <= FETCH;
         end
      end
   end

   // ---- FIFO storage: data only, never reset ----
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= rsp_pc;
         instr_mem[wr_ptr] <= imem_rsp_data;
      end
   end

endmodule
